// File: rtl/lsu_apb_seq.sv
// lsu_apb_seq: sequential RV32 load/store unit issuing byte/half/word accesses
// as one or more APB beats of BUS_W bits, with strobes, misalignment and PREADY timeout.
module lsu_apb_seq #(
  parameter int ADDR_W  = 32,
  parameter int BUS_W   = 16,
  parameter int TIMEOUT = 0,
  localparam int IW     = (BUS_W >= 32) ? 1 : $clog2(32 / BUS_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [BUS_W-1:0]  pwdata_o,
  output logic [BUS_W/8-1:0] pstrb_o,
  input  logic [BUS_W-1:0]  prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              chunk_valid_o,
  output logic [BUS_W-1:0]  chunk_o,
  output logic [IW-1:0]     chunk_idx_o,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic              resp_timeout_o,
  output logic [31:0]       resp_rdata_o
);
  localparam int BW = BUS_W / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32)) begin : g_bad_bus
    $error("lsu_apb_seq: BUS_W must be 8, 16 or 32");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d, signed_q, signed_d, err_q, err_d, to_q, to_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, acc_q, acc_d;
  logic [IW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic        accept, illegal, narrow, last, psel;
  logic [3:0]  bytes, nbm1, mask;
  logic [1:0]  off;
  logic [31:0] rep, lane;

  function automatic logic [31:0] ext(input logic [1:0] sz, input logic sg, input logic [31:0] v);
    return sz == 2'd0 ? {{24{sg & v[7]}}, v[7:0]} :
           sz == 2'd1 ? {{16{sg & v[15]}}, v[15:0]} : v;
  endfunction

  assign accept  = req_valid_i & req_ready_o;
  assign illegal = (req_size_i == 2'd3) | (req_size_i == 2'd1 & req_addr_i[0]) |
                   (req_size_i == 2'd2 & |req_addr_i[1:0]);
  assign bytes   = 4'd1 << size_q;
  assign narrow  = bytes < 4'(BW);
  assign nbm1    = bytes > 4'(BW) ? bytes / 4'(BW) - 4'd1 : 4'd0;
  assign last    = 4'(beat_q) == nbm1;
  assign off     = addr_q[1:0] & 2'(BW - 1);
  assign mask    = size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111;
  assign rep     = size_q == 2'd0 ? {4{wdata_q[7:0]}} : size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
  assign lane    = 32'(prdata_i) >> {off, 3'b000};
  assign psel    = state_q == SETUP | state_q == ACCESS;

  assign req_ready_o    = state_q == IDLE | state_q == RESP;
  assign psel_o         = psel;
  assign penable_o      = state_q == ACCESS;
  assign pwrite_o       = psel & write_q;
  assign paddr_o        = psel ? (addr_q & ~ADDR_W'(BW - 1)) + ADDR_W'(beat_q) * ADDR_W'(BW) : '0;
  assign pwdata_o       = pwrite_o ? BUS_W'(rep >> (32'(beat_q) * BUS_W)) : '0;
  assign pstrb_o        = pwrite_o ? (narrow ? BW'(mask << off) : '1) : '0;
  assign chunk_valid_o  = state_q == ACCESS & pready_i & ~pslverr_i & ~write_q;
  assign chunk_o        = chunk_valid_o ? (narrow ? BUS_W'(ext(size_q, signed_q, lane)) : prdata_i) : '0;
  assign chunk_idx_o    = chunk_valid_o ? beat_q : '0;
  assign resp_valid_o   = state_q == RESP;
  assign resp_err_o     = resp_valid_o & err_q;
  assign resp_timeout_o = resp_valid_o & to_q;
  assign resp_rdata_o   = resp_valid_o & ~err_q & ~write_q ? ext(size_q, signed_q, acc_q) : '0;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = accept ? (illegal ? RESP : SETUP) : IDLE;
        if (accept) begin
          write_d  = req_write_i;
          signed_d = req_signed_i;
          size_d   = req_size_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          acc_d    = '0;
          beat_d   = '0;
          err_d    = illegal;
          to_d     = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (pready_i) begin
          // a slave error abandons the remaining beats
          state_d = (pslverr_i | last) ? RESP : SETUP;
          err_d   = pslverr_i;
          acc_d   = acc_q | (32'(chunk_o) << (32'(beat_q) * BUS_W));
          beat_d  = beat_q + 1'b1;
        end else if (TIMEOUT != 0 && cnt_q + 1'b1 == CW'(TIMEOUT)) begin
          state_d = RESP;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      acc_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      acc_q    <= acc_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end
endmodule

// File: tb/tb_lsu_apb_seq.sv
// tb_lsu_apb_seq: scoreboard bench for lsu_apb_seq with a 16-bit (TIMEOUT=4) and an 8-bit instance;
// stimulus pushes expected beats/chunks/responses, per-DUT monitors pop and compare.
module tb_lsu_apb_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;

  logic [1:0]  rv = '0, rw = '0, rs = '0;
  logic [1:0]  rsz [2];
  logic [31:0] ra [2], rwd [2];

  logic        rdy16, psel16, pen16, pwr16, prdy16, perr16, cv16, rsv16, rse16, rto16;
  logic [31:0] paddr16, rrd16;
  logic [15:0] pwd16, prd16, ch16, rd_lo, rd_hi;
  logic [1:0]  pstrb16;
  logic [0:0]  ci16;

  logic        rdy8, psel8, pen8, pwr8, prdy8, cv8, rsv8, rse8, rto8;
  logic        perr8 = 1'b0;
  logic [31:0] paddr8, rrd8;
  logic [7:0]  pwd8, prd8, ch8;
  logic [0:0]  pstrb8;
  logic [1:0]  ci8;
  logic [7:0]  lut [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  // slaves: 16-bit returns one of two words by address bit 1, 8-bit returns a byte table
  assign prd16 = paddr16[1] ? rd_hi : rd_lo;
  assign prd8  = lut[paddr8[1:0]];

  lsu_apb_seq #(.ADDR_W(32), .BUS_W(16), .TIMEOUT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(rv[0]), .req_ready_o(rdy16), .req_write_i(rw[0]),
    .req_size_i(rsz[0]), .req_signed_i(rs[0]), .req_addr_i(ra[0]), .req_wdata_i(rwd[0]),
    .paddr_o(paddr16), .psel_o(psel16), .penable_o(pen16), .pwrite_o(pwr16), .pwdata_o(pwd16),
    .pstrb_o(pstrb16), .prdata_i(prd16), .pready_i(prdy16), .pslverr_i(perr16),
    .chunk_valid_o(cv16), .chunk_o(ch16), .chunk_idx_o(ci16), .resp_valid_o(rsv16),
    .resp_err_o(rse16), .resp_timeout_o(rto16), .resp_rdata_o(rrd16));

  lsu_apb_seq #(.ADDR_W(32), .BUS_W(8), .TIMEOUT(0)) u8 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(rv[1]), .req_ready_o(rdy8), .req_write_i(rw[1]),
    .req_size_i(rsz[1]), .req_signed_i(rs[1]), .req_addr_i(ra[1]), .req_wdata_i(rwd[1]),
    .paddr_o(paddr8), .psel_o(psel8), .penable_o(pen8), .pwrite_o(pwr8), .pwdata_o(pwd8),
    .pstrb_o(pstrb8), .prdata_i(prd8), .pready_i(prdy8), .pslverr_i(perr8),
    .chunk_valid_o(cv8), .chunk_o(ch8), .chunk_idx_o(ci8), .resp_valid_o(rsv8),
    .resp_err_o(rse8), .resp_timeout_o(rto8), .resp_rdata_o(rrd8));

  typedef struct packed {logic [31:0] addr; logic wr; logic [15:0] wd; logic [1:0] strb;} beat_t;
  typedef struct packed {logic [15:0] d; logic [1:0] idx;} chunk_t;
  typedef struct packed {logic err; logic to; logic [31:0] rd; logic [31:0] cyc;} resp_t;
  beat_t  bq [2][$];
  chunk_t cq [2][$];
  resp_t  rq [2][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic observe(input int d, input logic done, input logic [31:0] pa, input logic pw,
                         input logic [15:0] pd, input logic [1:0] ps, input logic cv,
                         input logic [15:0] cd, input logic [1:0] ci, input logic rvl,
                         input logic re, input logic rt, input logic [31:0] rr);
    string p = d != 0 ? "u8" : "u16";
    beat_t b;
    chunk_t c;
    resp_t r;
    if (done) begin
      chk({p, " beat expected"}, 32'(bq[d].size() != 0), 1);
      if (bq[d].size() != 0) begin
        b = bq[d].pop_front();
        chk({p, " paddr"}, pa, b.addr);
        chk({p, " pwrite"}, 32'(pw), 32'(b.wr));
        if (b.wr) chk({p, " pwdata"}, 32'(pd), 32'(b.wd));
        chk({p, " pstrb"}, 32'(ps), 32'(b.strb));
      end
    end
    if (cv) begin
      chk({p, " chunk expected"}, 32'(cq[d].size() != 0), 1);
      if (cq[d].size() != 0) begin
        c = cq[d].pop_front();
        chk({p, " chunk"}, 32'(cd), 32'(c.d));
        chk({p, " chunk_idx"}, 32'(ci), 32'(c.idx));
      end
    end
    if (rvl) begin
      chk({p, " resp expected"}, 32'(rq[d].size() != 0), 1);
      if (rq[d].size() != 0) begin
        r = rq[d].pop_front();
        chk({p, " resp_err"}, 32'(re), 32'(r.err));
        chk({p, " resp_timeout"}, 32'(rt), 32'(r.to));
        chk({p, " resp_rdata"}, rr, r.rd);
        chk({p, " resp_cycle"}, 32'(cyc), r.cyc);
      end
    end
  endtask

  always @(negedge clk)
    observe(0, psel16 & pen16 & prdy16, paddr16, pwr16, pwd16, pstrb16, cv16, ch16, 2'(ci16),
            rsv16, rse16, rto16, rrd16);
  always @(negedge clk)
    observe(1, psel8 & pen8 & prdy8, paddr8, pwr8, 16'(pwd8), 2'(pstrb8), cv8, 16'(ch8), ci8,
            rsv8, rse8, rto8, rrd8);

  task automatic beat(input int d, input logic [31:0] a, input logic w, input logic [15:0] wd,
                      input logic [1:0] s);
    beat_t b = '{a, w, wd, s};
    bq[d].push_back(b);
  endtask

  task automatic chunk(input int d, input logic [15:0] v, input logic [1:0] i);
    chunk_t c = '{v, i};
    cq[d].push_back(c);
  endtask

  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic e, input logic t,
                       input logic [31:0] rd, input int lat, input bit exp_r, output int acc);
    int n = 0;
    resp_t r;
    @(posedge clk); #1;
    while (!(d != 0 ? rdy8 : rdy16) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("dut%0d ready within bound", d), 32'(n < 200), 1);
    acc = cyc;
    if (exp_r) begin
      r = '{e, t, rd, 32'(acc + lat)};
      rq[d].push_back(r);
    end
    rv[d] = 1'b1; rw[d] = w; rsz[d] = sz; rs[d] = sg; ra[d] = a; rwd[d] = wd;
    @(posedge clk); #1;
    rv[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (rq[d].size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d drained within bound", d), 32'(n < 200), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n;
    rsz = '{2'd0, 2'd0}; ra = '{32'd0, 32'd0}; rwd = '{32'd0, 32'd0};
    prdy16 = 1'b1; perr16 = 1'b0; prdy8 = 1'b1; rd_lo = '0; rd_hi = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(rdy16), 1);
    chk("reset psel", 32'(psel16), 0);
    chk("reset penable", 32'(pen16), 0);
    chk("reset paddr", paddr16, 0);
    chk("reset pstrb", 32'(pstrb16), 0);
    chk("reset resp_valid", 32'(rsv16), 0);
    chk("reset chunk_valid", 32'(cv16), 0);
    chk("reset resp_rdata", rrd16, 0);
    chk("reset u8 req_ready", 32'(rdy8), 1);
    rst_n = 1'b1;

    // 16-bit stores, issued back-to-back, then illegal requests
    beat(0, 32'h100, 1, 16'hBEEF, 2'b11);
    beat(0, 32'h102, 1, 16'hDEAD, 2'b11);
    issue(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 5, 1, a1);
    beat(0, 32'h100, 1, 16'h5A5A, 2'b10);
    issue(0, 1, 2'd0, 0, 32'h101, 32'h1234565A, 0, 0, 0, 3, 1, a1);
    beat(0, 32'h106, 1, 16'h1234, 2'b11);
    issue(0, 1, 2'd1, 0, 32'h106, 32'hCAFE1234, 0, 0, 0, 3, 1, a1);
    issue(0, 1, 2'd1, 0, 32'h101, 32'h0000ABCD, 1, 0, 0, 1, 1, a1);
    issue(0, 0, 2'd3, 0, 32'h100, 32'h0, 1, 0, 0, 1, 1, a1);
    wait_idle(0);

    rd_hi = 16'h80AA; rd_lo = 16'h8001;
    beat(0, 32'h202, 0, 16'h0, 2'b00);
    chunk(0, 16'hFF80, 0);
    issue(0, 0, 2'd0, 1, 32'h203, 32'h0, 0, 0, 32'hFFFFFF80, 3, 1, a1);
    beat(0, 32'h202, 0, 16'h0, 2'b00);
    chunk(0, 16'h0080, 0);
    issue(0, 0, 2'd0, 0, 32'h203, 32'h0, 0, 0, 32'h00000080, 3, 1, a1);
    beat(0, 32'h204, 0, 16'h0, 2'b00);
    chunk(0, 16'h8001, 0);
    issue(0, 0, 2'd1, 1, 32'h204, 32'h0, 0, 0, 32'hFFFF8001, 3, 1, a1);
    wait_idle(0);

    rd_lo = 16'h5678; rd_hi = 16'h1234;
    beat(0, 32'h44, 0, 16'h0, 2'b00);
    beat(0, 32'h46, 0, 16'h0, 2'b00);
    chunk(0, 16'h5678, 0);
    chunk(0, 16'h1234, 1);
    issue(0, 0, 2'd2, 0, 32'h44, 32'h0, 0, 0, 32'h12345678, 5, 1, a1);
    wait_idle(0);

    perr16 = 1'b1;
    beat(0, 32'h40, 0, 16'h0, 2'b00);
    issue(0, 0, 2'd2, 0, 32'h40, 32'h0, 1, 0, 32'h0, 3, 1, a1);
    wait_idle(0);
    perr16 = 1'b0;

    // PREADY held low: 4 ACCESS cycles then timeout; next request accepted in RESP
    prdy16 = 1'b0;
    issue(0, 0, 2'd2, 0, 32'h80, 32'h0, 1, 1, 32'h0, 6, 1, a1);
    issue(0, 0, 2'd2, 0, 32'h82, 32'h0, 1, 0, 32'h0, 1, 1, a2);
    chk("accept in timeout RESP cycle", 32'(a2), 32'(a1 + 6));
    wait_idle(0);
    prdy16 = 1'b1;

    // 8-bit bus
    for (int k = 0; k < 4; k++) begin
      beat(1, 32'h300 + 32'(k), 0, 16'h0, 2'b00);
      chunk(1, 16'(lut[k]), 2'(k));
    end
    issue(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, 0, 32'h44332211, 9, 1, a1);
    beat(1, 32'h12, 1, 16'h00EF, 2'b01);
    beat(1, 32'h13, 1, 16'h00BE, 2'b01);
    issue(1, 1, 2'd1, 0, 32'h12, 32'h0000BEEF, 0, 0, 0, 5, 1, a1);
    beat(1, 32'h13, 1, 16'h0077, 2'b01);
    issue(1, 1, 2'd0, 0, 32'h13, 32'hAABBCC77, 0, 0, 0, 3, 1, a1);
    wait_idle(1);

    // reset during ACCESS abandons the transfer without a response
    prdy8 = 1'b0;
    issue(1, 0, 2'd2, 0, 32'h300, 32'h0, 0, 0, 0, 0, 0, a1);
    n = 0;
    while (!pen8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("u8 reached ACCESS", 32'(pen8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset psel", 32'(psel8), 0);
    chk("async reset penable", 32'(pen8), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prdy8 = 1'b1;
    @(negedge clk);
    chk("req_ready after reset", 32'(rdy8), 1);

    n = 0;
    while (bq[0].size() + cq[0].size() + rq[0].size() + bq[1].size() + cq[1].size() + rq[1].size() != 0
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard empty", 32'(bq[0].size() + cq[0].size() + rq[0].size() +
                               bq[1].size() + cq[1].size() + rq[1].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_apb_seq.md
Name: lsu_apb_seq

Overview:
Parametrised sequential load/store unit that issues RV32 byte/half/word data accesses as one or more APB beats of BUS_W bits. It sits in the execute/mem/writeback stage between the decode-side control and DMEM. It adds several things the fixed 16-bit LSU lacks: configurable bus width, byte-lane strobes, misalignment detection, a per-beat load chunk stream for early writeback, and a PREADY timeout.

Parameters:
ADDR_W, 32, address width
BUS_W, 16, APB data width; legal values 8/16/32 (elaboration error otherwise)
TIMEOUT, 0, maximum ACCESS wait cycles per beat; 0 disables the timeout

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  LSU can accept a request
req_write_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal
req_signed_i  in  1  sign-extend load result
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  32  store data
paddr_o  out  ADDR_W  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  BUS_W  APB write data
pstrb_o  out  BUS_W/8  APB byte strobes
prdata_i  in  BUS_W  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB error
chunk_valid_o  out  1  one load beat completed
chunk_o  out  BUS_W  lane-aligned, extended beat data
chunk_idx_o  out  max(1,clog2(32/BUS_W))  beat index, 0 = least significant
resp_valid_o  out  1  transaction done (1-cycle pulse)
resp_err_o  out  1  misaligned access, illegal size, PSLVERR or timeout
resp_timeout_o  out  1  error cause was a timeout
resp_rdata_o  out  32  extended load result (0 for stores and errors)

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o=1. Asserting reset mid-transfer drops psel_o/penable_o asynchronously; the transaction is abandoned with no response.
- FSM: IDLE -> SETUP -> ACCESS -> (next beat: SETUP | last beat or error: RESP) -> IDLE/SETUP.
- req_ready_o=1 in IDLE and RESP. A request is accepted when req_valid_i & req_ready_o; acceptance in RESP gives back-to-back operation (RESP -> SETUP). All request fields are registered at acceptance.
- Legality check at acceptance. Misaligned means addr not a multiple of the access size; size 3 is illegal. Either case -> RESP next cycle with err=1 and no APB activity.
- Beat count N = max(1, bytes/(BUS_W/8)). Beat k address = (addr aligned down to BUS_W/8) + k*(BUS_W/8). Beats issue in ascending order.
- SETUP cycle: psel=1, penable=0; paddr, pwrite, pwdata, pstrb stable through ACCESS.
- ACCESS cycle: psel=1, penable=1. The beat completes on a cycle with pready_i=1.
- Stores: write data is replicated across lanes for sub-bus sizes. pstrb marks exactly the addressed bytes; for full-lane beats pstrb is all ones.
- Loads: pstrb=0. Beat k data is placed at bits [k*BUS_W +: BUS_W] of the result. For accesses narrower than the bus, the addressed lane is extracted and shifted down.
- Extension: the final result is extended from 8/16 bits to 32 (sign or zero per req_signed_i).
- chunk_valid_o pulses in the completion cycle of each load beat, with chunk_idx_o=k. chunk_o holds the extracted lane, extended to BUS_W when the access is narrower than BUS_W.
- pslverr_i at completion aborts the remaining beats -> RESP with err=1 and rdata=0. No chunk_valid_o pulse is produced for that beat.
- Timeout (TIMEOUT>0): a wait counter resets on entry to ACCESS and increments on each ACCESS cycle with pready_i=0. When the count reaches TIMEOUT, psel/penable drop and the FSM moves to RESP with err=1 and timeout=1.
- RESP lasts one cycle: resp_valid_o=1 and all response fields are valid. There is no back-pressure on responses.
- Latency with zero wait states: accept at cycle 0, response at cycle 2N+1.

Test Plan:
- BUS_W=16, store word 0xDEADBEEF @0x100, pready=1 -> beat0 paddr 0x100 pwdata 0xBEEF pstrb 2'b11; beat1 0x102 0xDEAD; resp_valid at cycle 5, err=0.
- BUS_W=16, signed byte load @0x203, prdata=0x80AA -> paddr 0x202, chunk_o=0xFF80 idx0, resp_rdata=0xFFFFFF80; same load unsigned -> 0x00000080.
- Half store @0x101 -> no psel, resp_valid at cycle 1 with err=1. Size=3 @0x100 -> same response.
- BUS_W=16, word load @0x40, pslverr on beat0 -> beat1 never issued, err=1, rdata=0, no chunk pulse.
- TIMEOUT=4, pready held 0 -> psel drops after 4 ACCESS cycles, err=1, timeout=1; next request is accepted in the RESP cycle.
- BUS_W=8 word load, prdata 0x11,0x22,0x33,0x44 -> chunk idx 0..3, resp_rdata=0x44332211. Reset asserted mid-ACCESS -> psel=0 immediately and req_ready_o=1 after release.
